// File: rtl/debounce_pulse_pkg.sv
// Shared state encodings and default constants for the debounce block.
package debounce_pulse_pkg;

    // Debounce FSM states. Bit 1 is the last accepted level and bit 0 marks
    // a qualification window in progress.
    typedef enum logic [1:0] {
        DB_STABLE_LO = 2'b00,
        DB_PEND_HI   = 2'b01,
        DB_STABLE_HI = 2'b10,
        DB_PEND_LO   = 2'b11
    } db_state_e;

    // 10 ms of stable input at 50 MHz.
    localparam int DB_STABLE_CNT_DEF = 500000;
    localparam int DB_CNT_W_DEF      = 19;

endpackage

// File: rtl/debounce_pulse_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q;

    // Shift the raw input through two flops to settle metastability.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            s1_q <= d;
            q    <= s1_q;
        end
    end

endmodule

// File: rtl/debounce_pulse.sv
// Pushbutton conditioner: synchronise, debounce with a consecutive-sample
// counter, and emit a registered level plus one-cycle rise/fall strobes.
module debounce_pulse
    import debounce_pulse_pkg::*;
#(
    parameter int   STABLE_CNT  = DB_STABLE_CNT_DEF,
    parameter int   CNT_W       = DB_CNT_W_DEF,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam db_state_e        RESET_STATE = RESET_LEVEL ? DB_STABLE_HI : DB_STABLE_LO;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             s;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_2ff #(
        .RESET_VAL (RESET_LEVEL)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (s)
    );

    // State, counter and output registers; reset wins over any transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            level_q <= RESET_LEVEL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next state: count consecutive samples that differ from the accepted
    // level; any sample that agrees again drops back and clears the count.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            DB_STABLE_LO: begin
                if (s) begin
                    state_d = DB_PEND_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            DB_PEND_HI: begin
                if (!s) begin
                    state_d = DB_STABLE_LO;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_STABLE_HI;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DB_STABLE_HI: begin
                if (!s) begin
                    state_d = DB_PEND_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            DB_PEND_LO: begin
                if (s) begin
                    state_d = DB_STABLE_HI;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_STABLE_LO;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    assign btn_level  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule
